// File: rtl/fetch_prefetch.sv
// Fetch stage with a prefetch queue: issues sequential word requests under a credit limit,
// buffers in-order responses, and drops stale in-flight responses after a redirect.
module fetch_prefetch #(
    parameter logic [31:0] BOOT_ADDRESS    = 32'h0000_0000,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter int          ADDR_SHIFT      = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        im_req,
    output logic [31:0] im_addr,
    input  logic        im_ready,
    input  logic        im_valid,
    input  logic [31:0] im_data,
    input  logic        branch_d,
    input  logic [31:0] branch_next_addr_d,
    input  logic        pc_write_m,
    input  logic [31:0] pc_next_addr_m,
    input  logic        stall_f,
    output logic [31:0] instruction_f,
    output logic [31:0] pc_f,
    output logic        valid_f
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t             queue_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [OUT_W-1:0]   outstanding_q, discard_q;
    logic [31:0]        pc_req_q, pc_resp_q;

    logic               redirect;
    logic [31:0]        target;
    logic               accept, push, pop, drop;
    logic [OUT_W-1:0]   stale_cnt;

    // NOTE: every signal gets a value on every path through always_comb, so no latch can form.
    always_comb begin
        redirect  = pc_write_m | branch_d;
        target    = pc_write_m ? pc_next_addr_m : branch_next_addr_d;
        im_req    = !rst && !redirect
                    && (int'(outstanding_q) < MAX_OUTSTANDING)
                    && (int'(outstanding_q) + int'(count_q) < DEPTH);
        accept    = im_req && im_ready;
        drop      = im_valid && (discard_q != '0);
        push      = im_valid && (discard_q == '0) && !redirect;
        valid_f   = (count_q != '0) && !redirect;
        pop       = valid_f && !stall_f;
        // Outstanding already includes pending discards, so on redirect every
        // in-flight request becomes stale, less the one retiring this cycle.
        stale_cnt = (im_valid && outstanding_q != '0) ? outstanding_q - OUT_W'(1) : outstanding_q;
    end

    assign im_addr       = pc_req_q >> ADDR_SHIFT;
    assign instruction_f = (count_q != '0) ? queue_q[rd_ptr_q].instr : 32'h0;
    assign pc_f          = (count_q != '0) ? queue_q[rd_ptr_q].pc    : pc_resp_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_req_q      <= BOOT_ADDRESS;
            pc_resp_q     <= BOOT_ADDRESS;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
        end else if (redirect) begin
            pc_req_q      <= target;
            pc_resp_q     <= target;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= stale_cnt;
            discard_q     <= stale_cnt;
        end else begin
            if (accept)
                pc_req_q <= pc_req_q + 32'd4;
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
                pc_resp_q <= pc_resp_q + 32'd4;
            end
            if (pop)
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);

            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase

            case ({accept, im_valid})
                2'b10:   outstanding_q <= outstanding_q + OUT_W'(1);
                2'b01:   outstanding_q <= outstanding_q - OUT_W'(1);
                default: outstanding_q <= outstanding_q;
            endcase

            if (drop)
                discard_q <= discard_q - OUT_W'(1);
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push)
            queue_q[wr_ptr_q] <= '{pc: pc_resp_q, instr: im_data};
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && count_q == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch with an in-order, fixed-latency instruction memory model.
module tb_fetch_prefetch;

    localparam logic [31:0] TAG = 32'hC0DE_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ready;
    logic        im_valid;
    logic [31:0] im_data;
    logic        branch_d;
    logic [31:0] branch_next_addr_d;
    logic        pc_write_m;
    logic [31:0] pc_next_addr_m;
    logic        stall_f;
    logic [31:0] instruction_f;
    logic [31:0] pc_f;
    logic        valid_f;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;

    resp_t pend[$];
    int    cyc, lat, n_checks, n_fail, n_acc, max_inflight, nv, acc0;
    logic [31:0] exp_pc;
    bit    saw_80;

    fetch_prefetch #(
        .BOOT_ADDRESS(32'h0000_0000), .DEPTH(4), .MAX_OUTSTANDING(2), .ADDR_SHIFT(2)
    ) dut (
        .clk(clk), .rst(rst), .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready),
        .im_valid(im_valid), .im_data(im_data), .branch_d(branch_d),
        .branch_next_addr_d(branch_next_addr_d), .pc_write_m(pc_write_m),
        .pc_next_addr_m(pc_next_addr_m), .stall_f(stall_f),
        .instruction_f(instruction_f), .pc_f(pc_f), .valid_f(valid_f)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: present the due response, then let outputs settle.
    task automatic settle();
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            im_valid = 1'b1;
            im_data  = TAG + pend[0].addr;
        end else begin
            im_valid = 1'b0;
            im_data  = 32'h0;
        end
        #1;
    endtask

    // Record this cycle's handshakes, then move to the next falling edge.
    task automatic advance();
        if (im_req && im_ready) begin
            pend.push_back('{addr: im_addr, due: cyc + lat});
            n_acc++;
            if (im_addr == 32'h80) saw_80 = 1'b1;
        end
        if (pend.size() > max_inflight) max_inflight = pend.size();
        if (im_valid) void'(pend.pop_front());
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pend.delete();
        im_valid   = 1'b0;
        im_data    = 32'h0;
        branch_d   = 1'b0;
        pc_write_m = 1'b0;
        stall_f    = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        rst = 1'b1; im_ready = 1'b1; im_valid = 1'b0; im_data = 32'h0;
        branch_d = 1'b0; branch_next_addr_d = 32'h0; pc_write_m = 1'b0; pc_next_addr_m = 32'h0;
        stall_f = 1'b0; lat = 1; cyc = 0; n_checks = 0; n_fail = 0; n_acc = 0;
        max_inflight = 0; saw_80 = 1'b0;

        // Reset state
        @(negedge clk); #1;
        check("rst_valid", 32'(valid_f), 32'd0);
        check("rst_req",   32'(im_req),  32'd0);
        check("rst_pc",    pc_f,          32'h0);
        check("rst_instr", instruction_f, 32'h0);
        @(negedge clk); rst = 1'b0; cyc = 0;

        // Streaming, 1-cycle memory latency
        settle(); check("t1_addr0", im_addr, 32'd0); check("t1_req0", 32'(im_req), 32'd1);
        check("t1_valid0", 32'(valid_f), 32'd0); advance();
        settle(); check("t1_addr1", im_addr, 32'd1); check("t1_valid1", 32'(valid_f), 32'd0); advance();
        settle(); check("t1_valid2", 32'(valid_f), 32'd1); check("t1_pc2", pc_f, 32'h0);
        check("t1_instr2", instruction_f, TAG); check("t1_addr2", im_addr, 32'd2); advance();
        settle(); check("t1_pc3", pc_f, 32'h4); check("t1_valid3", 32'(valid_f), 32'd1); advance();
        settle(); check("t1_pc4", pc_f, 32'h8); check("t1_instr4", instruction_f, TAG + 32'd2); advance();

        // Stall fills the queue, then drains in order
        do_reset(); stall_f = 1'b1; acc0 = n_acc;
        for (int i = 0; i < 10; i++) begin settle(); advance(); end
        settle();
        check("t2_accepts", 32'(n_acc - acc0), 32'd4);
        check("t2_req_full", 32'(im_req), 32'd0);
        check("t2_valid", 32'(valid_f), 32'd1);
        check("t2_pc0", pc_f, 32'h0);
        stall_f = 1'b0; advance();
        settle(); check("t2_pc1", pc_f, 32'h4); check("t2_req_free", 32'(im_req), 32'd1);
        check("t2_addr", im_addr, 32'd4); advance();
        settle(); check("t2_pc2", pc_f, 32'h8); advance();
        settle(); check("t2_pc3", pc_f, 32'hC); check("t2_instr3", instruction_f, TAG + 32'd3); advance();

        // Request-to-valid_f latency of 3 cycles: credit-limited to 2 instructions per 3 cycles
        do_reset(); lat = 2; max_inflight = 0; nv = 0; exp_pc = 32'h0;
        for (int i = 0; i < 15; i++) begin
            settle();
            if (valid_f) begin check("t3_pc", pc_f, exp_pc); exp_pc += 32'h4; nv++; end
            advance();
        end
        check("t3_throughput", 32'(nv), 32'd8);
        check("t3_max_inflight", 32'(max_inflight), 32'd2);

        // Branch with two requests in flight
        do_reset(); lat = 2;
        settle(); advance(); settle(); advance();
        branch_d = 1'b1; branch_next_addr_d = 32'h100;
        settle(); check("t4_valid_br", 32'(valid_f), 32'd0); check("t4_req_br", 32'(im_req), 32'd0);
        advance(); branch_d = 1'b0;
        settle(); check("t4_req_after", 32'(im_req), 32'd1); check("t4_addr_after", im_addr, 32'h40);
        check("t4_valid3", 32'(valid_f), 32'd0); advance();
        settle(); check("t4_stale_drop", 32'(valid_f), 32'd0); advance();
        settle(); check("t4_valid5", 32'(valid_f), 32'd0); advance();
        settle(); check("t4_valid6", 32'(valid_f), 32'd1); check("t4_pc6", pc_f, 32'h100);
        check("t4_instr6", instruction_f, TAG + 32'h40); advance();
        settle(); check("t4_pc7", pc_f, 32'h104); check("t4_instr7", instruction_f, TAG + 32'h41); advance();

        // Simultaneous branch and PC write: the memory-stage target wins
        do_reset(); lat = 1; saw_80 = 1'b0;
        for (int i = 0; i < 3; i++) begin settle(); advance(); end
        branch_d = 1'b1; branch_next_addr_d = 32'h200; pc_write_m = 1'b1; pc_next_addr_m = 32'h300;
        settle(); check("t5_valid_br", 32'(valid_f), 32'd0); check("t5_req_br", 32'(im_req), 32'd0);
        advance(); branch_d = 1'b0; pc_write_m = 1'b0;
        settle(); check("t5_addr", im_addr, 32'hC0); check("t5_req", 32'(im_req), 32'd1); advance();
        settle(); check("t5_valid5", 32'(valid_f), 32'd0); advance();
        settle(); check("t5_valid6", 32'(valid_f), 32'd1); check("t5_pc6", pc_f, 32'h300);
        check("t5_instr6", instruction_f, TAG + 32'hC0); advance();
        check("t5_no_200", 32'(saw_80), 32'd0);

        // Reset mid-stream with a non-empty queue
        do_reset(); lat = 1; stall_f = 1'b1;
        for (int i = 0; i < 4; i++) begin settle(); advance(); end
        settle(); check("t6_pre_valid", 32'(valid_f), 32'd1);
        rst = 1'b1; pend.delete(); im_valid = 1'b0; im_data = 32'h0; stall_f = 1'b0;
        #1;
        check("t6_rst_valid", 32'(valid_f), 32'd0);
        check("t6_rst_req",   32'(im_req),  32'd0);
        check("t6_rst_pc",    pc_f,          32'h0);
        @(negedge clk); @(negedge clk); rst = 1'b0; cyc = 0;
        settle(); check("t6_req", 32'(im_req), 32'd1); check("t6_addr", im_addr, 32'd0); advance();
        settle(); check("t6_valid1", 32'(valid_f), 32'd0); advance();
        settle(); check("t6_valid2", 32'(valid_f), 32'd1); check("t6_pc", pc_f, 32'h0);
        check("t6_instr", instruction_f, TAG); advance();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
